br_tag_unit: RTL
================

BR_TAG_UNIT -- requirements
Module: br_tag_unit

Interface
REQ-001 Parameter: WIDTH_BRM, default 4, branch-tag width; DEPTH = 2**WIDTH_BRM in-flight branches.
REQ-002 Parameter: WIDTH_PC, default 32, PC width.
REQ-003 Port: i_clk  in  1  the single clock; all state updates on rising edge.
REQ-004 Port: i_rst_n  in  1  reset, asynchronous, active-low.
REQ-005 Port: i_alloc  in  1  decode requests a tag for one branch/jump this cycle.
REQ-006 Port: o_ready  out  1  a tag is available and i_alloc will be accepted.
REQ-007 Port: o_tag  out  WIDTH_BRM  tag granted when i_alloc & o_ready.
REQ-008 Port: i_res_valid  in  1  branch stage resolved one branch (its o_valid).
REQ-009 Port: i_brmask  in  WIDTH_BRM+1  {kill, tag+1} from the branch stage.
REQ-010 Port: i_PC  in  WIDTH_PC  corrected target PC from the branch stage.
REQ-011 Port: o_redirect  out  1  one-cycle pulse: fetch restarts at o_PC.
REQ-012 Port: o_PC  out  WIDTH_PC  registered redirect target.
REQ-013 Port: o_flush  out  1  squash all younger speculative work; high during RECOVER.
REQ-014 Port: o_count  out  WIDTH_BRM+1  in-flight (unresolved) tags.
REQ-015 Port: o_error  out  1  sticky protocol-violation flag.

Function
REQ-016 State: head (oldest unresolved tag), tail (next tag to grant), count, both pointers WIDTH_BRM bits, wrapping modulo DEPTH.
REQ-017 FSM states NORMAL and RECOVER; NORMAL->RECOVER on accepted kill; RECOVER->NORMAL unconditionally next cycle.
REQ-018 o_tag = tail combinationally; o_ready = (state==NORMAL) & (count<DEPTH) & ~(i_res_valid & i_brmask[WIDTH_BRM]).
REQ-019 Accepted alloc (i_alloc & o_ready): tail <= tail+1, count +1.
REQ-020 Resolve without kill (i_res_valid, kill=0): head <= head+1, count -1; expected tag = i_brmask[WIDTH_BRM-1:0]-1 must equal head.
REQ-021 Resolve with kill: head <= i_brmask[WIDTH_BRM-1:0], tail <= i_brmask[WIDTH_BRM-1:0], count <= 0, o_PC <= i_PC, o_redirect <= 1 next cycle, state <= RECOVER.
REQ-022 Alloc and non-kill resolve same cycle: both applied, count unchanged.
REQ-023 Alloc and kill same cycle: kill wins, alloc not granted (o_ready low).
REQ-024 In RECOVER: o_flush=1, o_ready=0, i_res_valid ignored (no state change).
REQ-025 Resolve while count==0 or tag mismatch: o_error <= 1 (sticky), pointers/count unchanged.
REQ-026 i_alloc while ~o_ready: ignored, no error.
REQ-027 Latency: o_redirect/o_PC/o_flush valid exactly one cycle after the kill input cycle.
REQ-028 Full: count==DEPTH -> o_ready=0; a resolve that cycle frees a slot usable next cycle.

Reset
REQ-029 Asserting i_rst_n low at any time, including mid-RECOVER, forces immediately: head=0, tail=0, count=0, state=NORMAL, o_PC=0, o_redirect=0, o_flush=0, o_error=0.
REQ-030 First cycle after release: o_ready=1, o_tag=0.

Structure
REQ-031 Shared package holds FSM state encoding (NORMAL=0, RECOVER=1) and default WIDTH_BRM/WIDTH_PC constants used with the branch stage.
REQ-032 Pointer/count storage uses the codebase's existing enable-register sub-module (register) for every state element; no other sub-module.

Verification
REQ-033 Reset, 3 allocs -> o_tag 0,1,2; o_count=3; o_ready=1.
REQ-034 Alloc 16 (WIDTH_BRM=4) -> o_count=16, o_ready=0; resolve tag 0 ({0,4'h1}) -> next cycle o_ready=1, o_tag=0 (wrap).
REQ-035 Alloc 3, resolve {1,4'h1} with i_PC=32'h100 -> next cycle o_redirect=1, o_PC=32'h100, o_flush=1, o_ready=0; cycle after o_ready=1, o_tag=1, o_count=0.
REQ-036 Alloc and non-kill resolve same cycle with count=2 -> o_count stays 2, head and tail both +1.
REQ-037 Resolve with count=0, or {0,4'h5} when head=0 -> o_error=1 and stays 1 until reset.
REQ-038 Assert i_rst_n=0 during RECOVER -> o_flush, o_redirect drop immediately; all outputs at reset values.

Source files
------------

// File: rtl/br_tag_unit_pkg.sv
// Shared definitions for the branch-tag unit and the branch stage it serves.
package br_tag_unit_pkg;

  // Recovery FSM encoding, shared with the branch stage.
  typedef enum logic {
    NORMAL  = 1'b0,
    RECOVER = 1'b1
  } brt_state_e;

  // Default tag and PC widths used across the pipeline.
  localparam int BRM_WIDTH = 4;
  localparam int PC_WIDTH  = 32;

endpackage

// File: rtl/br_tag_unit_register.sv
// Enable register with asynchronous active-low clear; holds every state element.
module register #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Load d when enabled; clear to zero whenever reset is asserted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/br_tag_unit.sv
// Branch-tag allocator: grants tags in order, retires them on resolve,
// and rewinds the tag ring plus redirects fetch on a mispredict kill.
module br_tag_unit
  import br_tag_unit_pkg::*;
#(
  parameter int WIDTH_BRM = BRM_WIDTH,
  parameter int WIDTH_PC  = PC_WIDTH
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_alloc,
  output logic                 o_ready,
  output logic [WIDTH_BRM-1:0] o_tag,
  input  logic                 i_res_valid,
  input  logic [WIDTH_BRM:0]   i_brmask,
  input  logic [WIDTH_PC-1:0]  i_PC,
  output logic                 o_redirect,
  output logic [WIDTH_PC-1:0]  o_PC,
  output logic                 o_flush,
  output logic [WIDTH_BRM:0]   o_count,
  output logic                 o_error
);

  // Count saturates at DEPTH, so it needs one extra bit over the pointers.
  localparam logic [WIDTH_BRM:0] DEPTH_C = (WIDTH_BRM+1)'(1) << WIDTH_BRM;

  logic [WIDTH_BRM-1:0] head, head_next;
  logic [WIDTH_BRM-1:0] tail, tail_next;
  logic [WIDTH_BRM:0]   count, count_next;
  logic [0:0]           state_bits;
  brt_state_e           state, state_next;
  logic                 error_next;

  logic                 in_kill;
  logic                 normal;
  logic                 alloc_acc;
  logic                 res_act;
  logic                 kill_act;
  logic                 res_plain;
  logic                 res_ok;
  logic                 res_bad;
  logic [WIDTH_BRM-1:0] res_ptr;

  assign state   = brt_state_e'(state_bits);
  assign normal  = (state == NORMAL);
  assign in_kill = i_res_valid & i_brmask[WIDTH_BRM];
  assign res_ptr = i_brmask[WIDTH_BRM-1:0];

  assign o_tag     = tail;
  assign o_count   = count;
  assign o_ready   = normal & (count < DEPTH_C) & ~in_kill;
  assign alloc_acc = i_alloc & o_ready;

  // Resolves are only acted on in NORMAL; RECOVER swallows them silently.
  assign res_act   = i_res_valid & normal;
  assign kill_act  = res_act & i_brmask[WIDTH_BRM];
  assign res_plain = res_act & ~i_brmask[WIDTH_BRM];
  // The branch stage sends tag+1, so the resolved tag is res_ptr-1.
  assign res_ok    = res_plain & (count != '0) & ((res_ptr - 1'b1) == head);
  assign res_bad   = res_plain & ~res_ok;

  // Next-state for pointers, count, FSM and the sticky error flag.
  always_comb begin
    head_next  = head;
    tail_next  = tail;
    count_next = count;
    state_next = NORMAL;
    error_next = o_error | res_bad;
    if (kill_act) begin
      // Everything younger than the killed branch is discarded.
      head_next  = res_ptr;
      tail_next  = res_ptr;
      count_next = '0;
      state_next = RECOVER;
    end else begin
      if (res_ok) head_next = head + 1'b1;
      if (alloc_acc) tail_next = tail + 1'b1;
      case ({alloc_acc, res_ok})
        2'b10:   count_next = count + 1'b1;
        2'b01:   count_next = count - 1'b1;
        default: count_next = count;
      endcase
    end
  end

  register #(.W(WIDTH_BRM)) u_head (
    .clk(i_clk), .rst_n(i_rst_n), .en(1'b1), .d(head_next), .q(head)
  );

  register #(.W(WIDTH_BRM)) u_tail (
    .clk(i_clk), .rst_n(i_rst_n), .en(1'b1), .d(tail_next), .q(tail)
  );

  register #(.W(WIDTH_BRM+1)) u_count (
    .clk(i_clk), .rst_n(i_rst_n), .en(1'b1), .d(count_next), .q(count)
  );

  register #(.W(1)) u_state (
    .clk(i_clk), .rst_n(i_rst_n), .en(1'b1), .d(state_next), .q(state_bits)
  );

  // Redirect target is captured only on an accepted kill.
  register #(.W(WIDTH_PC)) u_pc (
    .clk(i_clk), .rst_n(i_rst_n), .en(kill_act), .d(i_PC), .q(o_PC)
  );

  // Redirect pulse and flush both follow the kill by exactly one cycle.
  register #(.W(1)) u_redirect (
    .clk(i_clk), .rst_n(i_rst_n), .en(1'b1), .d(kill_act), .q(o_redirect)
  );

  register #(.W(1)) u_flush (
    .clk(i_clk), .rst_n(i_rst_n), .en(1'b1), .d(kill_act), .q(o_flush)
  );

  register #(.W(1)) u_error (
    .clk(i_clk), .rst_n(i_rst_n), .en(1'b1), .d(error_next), .q(o_error)
  );

endmodule
